pipe_skid_register: RTL

Parametrised pipeline-stage register with a two-entry skid buffer, valid/ready handshake on both sides, and synchronous flush. It is the general replacement for the fixed per-stage registers between IF/ID, ID/EX, EX/MEM and MEM/WB. Each instance carries an opaque payload (instruction, PC, prediction bit, control fields) packed by the stage that owns it. The registered input-side ready removes the combinational stall path that otherwise runs back through the pipeline.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_skid_register.sv | 51 +++++
 2 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, NOP instruction and per-stage payload widths for pipeline registers.
package pipe_pkg;
  typedef logic [1:0] state_t;
  localparam state_t EMPTY = 2'd0;
  localparam state_t ONE   = 2'd1;
  localparam state_t FULL  = 2'd2;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam int IF_ID_W  = 65;
  localparam int ID_EX_W  = 65;
  localparam int EX_MEM_W = 65;
  localparam int MEM_WB_W = 65;
endpackage

// File: rtl/pipe_skid_register.sv
// pipe_skid_register: pipeline-stage register with two-entry skid buffer and flush.
// Define PIPE_SKID_FLUSH_NOP_EN to make flush present a valid NOP_PAYLOAD instead of going empty.
module pipe_skid_register
  import pipe_pkg::*;
#(
  parameter int DATA_W = 65,
  parameter logic [DATA_W-1:0] NOP_PAYLOAD = 65'h0_0000_0000_0000_0013
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  input  logic              flush_i,
  output logic [1:0]        occupancy_o
);
`ifdef PIPE_SKID_FLUSH_NOP_EN
  localparam bit FLUSH_NOP = 1'b1;
`else
  localparam bit FLUSH_NOP = 1'b0;
`endif
  state_t state, state_nx;
  logic [DATA_W-1:0] m, s;
  logic push, pop;
  assign in_ready_o  = state != FULL;
  assign out_valid_o = state != EMPTY;
  assign occupancy_o = state;
  assign out_data_o  = m;
  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;
  // push is impossible in FULL, so +/-1 covers every legal transition
  always_comb
    state_nx = flush_i ? (FLUSH_NOP ? ONE : EMPTY) :
               (push & ~pop) ? state_t'(state + 2'd1) :
               (pop & ~push) ? state_t'(state - 2'd1) : state;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= EMPTY;
      m     <= '0;
      s     <= '0;
    end else begin
      state <= state_nx;
      if (flush_i) m <= FLUSH_NOP ? NOP_PAYLOAD : m;
      else if (push && (state == EMPTY || pop)) m <= in_data_i;
      else if (pop && state == FULL) m <= s;
      if (!flush_i && push && !pop && state == ONE) s <= in_data_i;
    end
endmodule
